// File: rtl/uart_txrx_core.sv
// Full-duplex UART core: independent TX and RX state machines that share only the
// clock and reset. Parity, stop-bit count and data width are set by parameters.
module uart_txrx_core #(
    parameter int unsigned SYS_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 send_req,
    output logic                 send_ack,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 recv_req,
    input  logic                 recv_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned CLKS_PER_BIT = SYS_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_SIZE);

    localparam logic [CNT_W-1:0] BaudLast  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BaudMid   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] DataLast  = BIT_W'(DATA_SIZE - 1);
    localparam logic [BIT_W-1:0] StopLast  = BIT_W'(STOP_BITS - 1);
    localparam logic             HasParity = (PARITY_MODE != 0);
    localparam logic             ParOdd    = (PARITY_MODE == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------ TX
    state_e               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_baud_end;

    assign tx_baud_end = (tx_baud_q == BaudLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= StIdle;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_baud_d  = tx_baud_end ? '0 : tx_baud_q + CNT_W'(1);
        unique case (tx_state_q)
            StIdle: begin
                tx_baud_d = '0;
                tx_bit_d  = '0;
                if (send_req) begin
                    tx_data_d  = din;
                    tx_state_d = StStart;
                end
            end
            StStart: if (tx_baud_end) tx_state_d = StData;
            StData: begin
                if (tx_baud_end) begin
                    if (tx_bit_q == DataLast) begin
                        tx_bit_d   = '0;
                        tx_state_d = HasParity ? StParity : StStop;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            StParity: if (tx_baud_end) tx_state_d = StStop;
            StStop: begin
                if (tx_baud_end) begin
                    if (tx_bit_q == StopLast) begin
                        tx_bit_d   = '0;
                        tx_state_d = StIdle;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    always_comb begin
        tx       = 1'b1;
        send_ack = 1'b0;
        unique case (tx_state_q)
            StIdle:   send_ack = send_req;
            StStart:  tx = 1'b0;
            StData:   tx = tx_data_q[tx_bit_q];
            StParity: tx = (^tx_data_q) ^ ParOdd;
            StStop:   tx = 1'b1;
            default:  tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    state_e               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 recv_req_q, recv_req_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 rx_mid, rx_end, frame_done, par_bad, accept;

    assign rx_mid = (rx_baud_q == BaudMid);
    assign rx_end = (rx_baud_q == BaudLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            dout_q     <= '0;
            recv_req_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            dout_q     <= dout_d;
            recv_req_q <= recv_req_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_baud_d  = rx_end ? '0 : rx_baud_q + CNT_W'(1);
        unique case (rx_state_q)
            StIdle: begin
                rx_baud_d = '0;
                rx_bit_d  = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = StStart;
            end
            StStart: begin
                // A line that is high again at mid-start was only a glitch.
                if (rx_mid && rx_sync_q) rx_state_d = StIdle;
                else if (rx_end)         rx_state_d = StData;
            end
            StData: begin
                if (rx_mid) rx_shift_d[rx_bit_q] = rx_sync_q;
                if (rx_end) begin
                    if (rx_bit_q == DataLast) begin
                        rx_bit_d   = '0;
                        rx_state_d = HasParity ? StParity : StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            StParity: begin
                if (rx_mid) rx_par_d = rx_sync_q;
                if (rx_end) rx_state_d = StStop;
            end
            // The frame ends at mid first stop bit so the next start edge is never missed.
            StStop: if (rx_mid) rx_state_d = StIdle;
            default: rx_state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_done = (rx_state_q == StStop) && rx_mid;
        par_bad    = HasParity && (rx_par_q != ((^rx_shift_q) ^ ParOdd));
        accept     = frame_done && (!recv_req_q || recv_ack);
        dout_d     = accept ? rx_shift_q : dout_q;
        recv_req_d = accept ? 1'b1 : (recv_ack ? 1'b0 : recv_req_q);
        perr_d     = frame_done && par_bad;
        ferr_d     = frame_done && !rx_sync_q;
        ovr_d      = frame_done && !accept;
    end

    assign dout        = dout_q;
    assign recv_req    = recv_req_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: doc/uart_txrx_core.md
UART_TXRX_CORE -- requirements
Module: uart_txrx_core

Interface
REQ-001 The block SHALL have parameter SYS_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s; CLKS_PER_BIT = SYS_FREQ/BAUD_RATE (integer division, must be >= 4).
REQ-003 The block SHALL have parameter DATA_SIZE, default 8, data bits per frame, legal range 5-9.
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, where 0 = none, 1 = even and 2 = odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 The block SHALL have one clock and asynchronous active-low reset: clk (input, 1) and reset_n (input, 1).
REQ-007 The block SHALL have port rx, input, 1 bit, serial receive line, asynchronous to clk.
REQ-008 The block SHALL have port tx, output, 1 bit, serial transmit line, idle high.
REQ-009 The block SHALL have port din, input, DATA_SIZE bits, word to transmit.
REQ-010 The block SHALL have ports send_req (input, 1) and send_ack (output, 1): transmit request and capture acknowledge.
REQ-011 The block SHALL have port dout, output, DATA_SIZE bits, last received word.
REQ-012 The block SHALL have ports recv_req (output, 1) and recv_ack (input, 1): received-word valid and consumer acknowledge.
REQ-013 The block SHALL have ports parity_err, frame_err and overrun_err, each output, 1 bit.

Function
REQ-014 The bit counter and baud counter SHALL be sized to hold DATA_SIZE-1 and CLKS_PER_BIT-1 respectively; both wrap to 0 at terminal count.
REQ-015 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE = 0.
REQ-016 In IDLE with send_req = 1, TX SHALL latch din, pulse send_ack high for exactly 1 cycle, and enter START on the next cycle.
REQ-017 TX SHALL ignore send_req in any state other than IDLE. A held send_req starts a new frame on the first IDLE cycle after STOP.
REQ-018 Each TX bit SHALL last exactly CLKS_PER_BIT cycles, in this order: start bit (0), data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-019 Parity SHALL be the XOR of the data bits for even mode and its inverse for odd mode.
REQ-020 rx SHALL pass through a 2-flop synchroniser before any use. The receive path latency adds 2 cycles.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. A falling edge on synchronised rx in IDLE enters START.
REQ-022 RX SHALL sample each bit at count CLKS_PER_BIT/2 within the bit period.
REQ-023 If rx is 1 at the mid-start sample, RX SHALL treat it as a glitch and return to IDLE with no flags and no recv_req.
REQ-024 RX SHALL check only the first stop bit. If it samples 0, RX SHALL pulse frame_err for 1 cycle and still deliver the word.
REQ-025 On a parity mismatch, RX SHALL pulse parity_err for 1 cycle at frame completion and still deliver the word.
REQ-026 At frame completion with recv_req = 0, RX SHALL update dout and set recv_req = 1 on the next cycle.
REQ-027 recv_req SHALL stay high until a cycle with recv_ack = 1, then clear on the following cycle. recv_ack while recv_req = 0 SHALL be ignored.
REQ-028 If a frame completes while recv_req = 1 and recv_ack = 0, the new word SHALL be dropped, dout held, and overrun_err pulsed for 1 cycle.
REQ-029 If a frame completes in the same cycle as recv_ack = 1, the new word SHALL be delivered with no overrun, and recv_req SHALL remain high.
REQ-030 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-031 While reset_n = 0, outputs SHALL be tx = 1, send_ack = 0, recv_req = 0, dout = 0, and all error flags 0. Both FSMs SHALL be in IDLE and all counters 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no ack or flag. Release is synchronous to clk, and the block accepts a request on the first cycle after release.

Verification
REQ-033 Default parameters, din = 0xA5, send_req for 1 cycle -> send_ack 1 cycle; tx = 0 for 434 cycles, then 1,0,1,0,0,1,0,1 at 434 cycles each, then 1.
REQ-034 PARITY_MODE = 1, STOP_BITS = 2, send 0xA5 -> parity bit 0, then 868 cycles of tx = 1; with PARITY_MODE = 2 the parity bit is 1.
REQ-035 Loop tx to rx, send 0x3C -> recv_req rises; dout = 0x3C; no flags; recv_ack for 1 cycle -> recv_req low on the next cycle.
REQ-036 Drive 0x11, then 0x22 on rx with no recv_ack -> dout = 0x11 and an overrun_err pulse at the end of the second frame.
REQ-037 rx low pulse of 100 cycles -> no recv_req. A frame with stop bit 0 -> frame_err pulse. A wrong parity bit -> parity_err pulse.
REQ-038 reset_n low mid-TX at data bit 3 -> tx = 1 immediately; after release, a new send completes correctly.
